// File: rtl/stream_input_pkg.sv
// Shared types and constants for the puzzle-stream input front end.
package stream_input_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Occupancy width for the default buffer depth; instances with another
  // DEPTH size their level ports from their own parameter.
  localparam int DEF_DEPTH = 4;
  localparam int LVL_W     = $clog2(DEF_DEPTH + 1);

endpackage

// File: rtl/stream_input_frontend_fifo.sv
// Registered DEPTH-entry FIFO with power-of-2 pointer wrap and flush.
module sync_fifo
  import stream_input_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         empty_o,
  output logic                         full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [PW-1:0]               r_wptr;
  logic [PW-1:0]               r_rptr;
  logic [LW-1:0]               r_level;
  logic                        w_push;
  logic                        w_pop;

  assign empty_o = (r_level == '0);
  assign full_o  = (r_level == LW'(DEPTH));
  assign w_push  = push & ~full_o;
  assign w_pop   = pop & ~empty_o;
  assign data_o  = r_mem[r_rptr];
  assign level_o = r_level;

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/stream_input_frontend.sv
// Frame-level input stage: header capture, payload buffering, last/done.
module stream_input_frontend
  import stream_input_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         init_i,
  input  logic                         stop_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         valid_1,
  output logic                         ready_1,
  output logic [WIDTH-1:0]             data_o,
  output logic                         valid_2,
  input  logic                         ready_2,
  output logic                         last_o,
  output logic [CNT_W-1:0]             total_num_turns_o,
  output logic [CNT_W-1:0]             count_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         done_o
);
  state_e           r_state;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_acc;
  logic             r_done;

  logic             w_rdy;
  logic             w_t1;
  logic             w_t2;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  // Intake ready from registered state only (plus stop_i), never from valid_1/ready_2.
  always_comb begin
    w_rdy = 1'b0;
    case (r_state)
      HDR:     w_rdy = ~stop_i;
      STREAM:  w_rdy = ~stop_i & ~w_full & (r_acc < r_total);
      default: w_rdy = 1'b0;
    endcase
  end

  assign ready_1 = w_rdy;
  assign valid_2 = ~w_empty;
  assign w_t1    = valid_1 & w_rdy;
  assign w_t2    = valid_2 & ready_2;
  // init_i discards any same-cycle transfer.
  assign w_push  = w_t1 & (r_state == STREAM) & ~init_i;
  assign w_pop   = w_t2 & ~init_i;

  assign last_o = valid_2 & (r_count == r_total - CNT_W'(1)) &
                  ((r_state == STREAM) | (r_state == DRAIN));
  assign total_num_turns_o = r_total;
  assign count_o           = r_count;
  assign done_o            = r_done;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (init_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .level_o (level_o),
    .empty_o (w_empty),
    .full_o  (w_full)
  );

  // Frame FSM with header, accepted and delivered counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_total <= '0;
      r_count <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
    end else if (init_i) begin
      r_state <= HDR;
      r_count <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
    end else begin
      if (w_t2) r_count <= r_count + CNT_W'(1);
      case (r_state)
        HDR: if (w_t1) begin
          r_total <= data_i[CNT_W-1:0];
          if (data_i[CNT_W-1:0] == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= STREAM;
          end
        end
        STREAM: if (w_t1) begin
          r_acc <= r_acc + CNT_W'(1);
          if (r_acc + CNT_W'(1) == r_total) r_state <= DRAIN;
        end
        DRAIN: if (w_t2 && (r_count == r_total - CNT_W'(1))) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        default: r_state <= r_state;
      endcase
    end
  end

endmodule
